// File: rtl/seg7_scan_driver_if.sv
// rtl/seg7_scan_driver_if.sv - control, value and display signals of the seven-segment scan driver
interface seg7_scan_driver_if;
  logic        enable;
  logic        load;
  logic [23:0] value;
  logic [5:0]  dp;
  logic        blank_lz;
  logic [7:0]  digit;
  logic [5:0]  select;
  logic        frame;

  modport master (
    output enable, load, value, dp, blank_lz,
    input  digit, select, frame
  );

  modport slave (
    input  enable, load, value, dp, blank_lz,
    output digit, select, frame
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - six-digit multiplexed seven-segment driver, double-buffered value
module seg7_scan_driver #(
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input logic              clk,
  input logic              rst,
  seg7_scan_driver_if.slave bus
);

  localparam int              TW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [TW-1:0]   TICK_LAST  = TW'(SCAN_DIV - 1);
  localparam logic [TW-1:0]   TICK_BLANK = TW'(BLANK_CYCLES);
  localparam logic [7:0]      DIGIT_OFF  = ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [5:0]      SEL_OFF    = ACTIVE_LOW ? 6'h3F : 6'h00;

  logic [TW-1:0] tick_q, tick_d;
  logic [2:0]    idx_q, idx_d;
  logic [30:0]   pending_q, pending_d;
  logic [30:0]   shadow_q, shadow_d;
  logic [7:0]    digit_q, digit_d;
  logic [5:0]    select_q, select_d;
  logic          frame_q, frame_d;

  logic [30:0]   load_word;
  logic          wrap;
  logic          boundary;
  logic [3:0]    nib [6];
  logic [5:0]    blank_run;
  logic [5:0]    dp_s;
  logic [6:0]    seg;
  logic [7:0]    digit_raw;
  logic [5:0]    select_raw;

  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    case (n)
      4'h0: return 7'h3F;
      4'h1: return 7'h06;
      4'h2: return 7'h5B;
      4'h3: return 7'h4F;
      4'h4: return 7'h66;
      4'h5: return 7'h6D;
      4'h6: return 7'h7D;
      4'h7: return 7'h07;
      4'h8: return 7'h7F;
      4'h9: return 7'h6F;
      4'hA: return 7'h77;
      4'hB: return 7'h7C;
      4'hC: return 7'h39;
      4'hD: return 7'h5E;
      4'hE: return 7'h79;
      default: return 7'h71;
    endcase
  endfunction

  always_comb begin
    load_word = {bus.value, bus.dp, bus.blank_lz};
    wrap      = (tick_q == TICK_LAST);
    boundary  = bus.enable && wrap && (idx_q == 3'd5);

    for (int i = 0; i < 6; i++) begin
      nib[i] = shadow_q[7 + 4*i +: 4];
    end
    dp_s = shadow_q[6:1];

    // A slot is blanked only while it and every higher nibble are zero; slot 0 always shows.
    blank_run    = '0;
    blank_run[5] = shadow_q[0] && (nib[5] == 4'h0);
    for (int i = 4; i >= 1; i--) begin
      blank_run[i] = blank_run[i+1] && (nib[i] == 4'h0);
    end

    seg        = blank_run[idx_q] ? 7'h00 : seg_decode(nib[idx_q]);
    digit_raw  = {dp_s[idx_q], seg};
    select_raw = (tick_q < TICK_BLANK) ? 6'h00 : (6'b1 << idx_q);

    pending_d = bus.load ? load_word : pending_q;
    shadow_d  = shadow_q;
    if (boundary) begin
      shadow_d = bus.load ? load_word : pending_q;
    end

    tick_d   = '0;
    idx_d    = '0;
    digit_d  = DIGIT_OFF;
    select_d = SEL_OFF;
    frame_d  = 1'b0;
    if (bus.enable) begin
      tick_d   = wrap ? '0 : tick_q + 1'b1;
      idx_d    = idx_q;
      if (wrap) begin
        idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
      end
      digit_d  = digit_raw ^ {8{ACTIVE_LOW}};
      select_d = select_raw ^ {6{ACTIVE_LOW}};
      frame_d  = boundary;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_q    <= '0;
      idx_q     <= '0;
      pending_q <= '0;
      shadow_q  <= '0;
      digit_q   <= DIGIT_OFF;
      select_q  <= SEL_OFF;
      frame_q   <= 1'b0;
    end else begin
      tick_q    <= tick_d;
      idx_q     <= idx_d;
      pending_q <= pending_d;
      shadow_q  <= shadow_d;
      digit_q   <= digit_d;
      select_q  <= select_d;
      frame_q   <= frame_d;
    end
  end

  assign bus.digit  = digit_q;
  assign bus.select = select_q;
  assign bus.frame  = frame_q;

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Six-digit multiplexed seven-segment display driver. It is the output stage that consumes the 24-bit hex value and decimal-point mask produced by the processor datapath, and drives the board's shared segment bus (digit) and digit enables (select).
- It time-multiplexes digits with a programmable scan rate and an anti-ghosting blank gap.
- It double-buffers the displayed value so a frame never shows a partly updated value (no tearing).

Parameters:
SCAN_DIV, 50000, clk cycles per digit slot (1 kHz per digit at 50 MHz); legal range ≥ BLANK_CYCLES+1
BLANK_CYCLES, 500, cycles at the start of each slot during which all selects are off
ACTIVE_LOW, 1, 1 = segments and selects active-low (board default); 0 = active-high

Ports:
clk  input  1  system clock, 50 MHz
rst  input  1  synchronous active-high reset
enable  input  1  1 = scanning; 0 = display dark, scan state cleared
load  input  1  single-cycle strobe: capture value/dp/blank_lz into pending register
value  input  24  six hex nibbles; value[3:0] is the rightmost digit (slot 0)
dp  input  6  decimal point per digit; dp[i] belongs to slot i
blank_lz  input  1  1 = suppress leading zeros
digit  output  8  segments {dp,g,f,e,d,c,b,a}, polarity per ACTIVE_LOW
select  output  6  digit enables; select[i] drives slot i, polarity per ACTIVE_LOW
frame  output  1  one-cycle pulse at the end of slot 5

Behaviour:
- "Off" means all bits inactive: 8'hFF / 6'h3F when ACTIVE_LOW=1, and 0 when ACTIVE_LOW=0.
- Reset (synchronous): tick=0, idx=0, pending=0, shadow=0, frame=0, digit=off, select=off.
- tick counts from 0 to SCAN_DIV-1 and then wraps. On wrap, idx advances 0→1→…→5→0.
- Frame boundary: tick==SCAN_DIV-1 and idx==5. In that cycle:
  - frame is registered high for exactly one cycle.
  - shadow ← pending.
- load: pending ← {value, dp, blank_lz} at any time. If load coincides with a frame boundary, shadow takes the incoming load data directly (bypass).
- The display is always driven from shadow. A mid-frame load never changes the current frame.
- Segment decode, active-high gfedcba:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
  - bit7 = dp[idx].
  - All 8 bits are inverted when ACTIVE_LOW=1.
- Leading-zero blanking (shadow blank_lz=1):
  - Slot i (i=5..1) is blanked when its nibble and every higher nibble are 0. Blanked means segments a–g are off.
  - The dp bit of a blanked slot is still driven from dp[i].
  - Slot 0 is never blanked.
  - The select for a blanked slot still asserts normally.
- Select per slot: off while tick < BLANK_CYCLES; otherwise only select[idx] is active.
- Outputs are registered: digit/select/frame reflect the (tick, idx) value of the previous cycle (latency 1).
- enable=0: tick and idx clear to 0, digit/select are off next cycle, frame=0. pending/shadow are held and load still works. On the first cycle with enable=1, scanning restarts at slot 0, tick 0.
- Reset asserted mid-slot: the cycle after the rst edge shows the reset state above. Any pending load in that cycle is discarded.

Test Plan:
Bench parameters: SCAN_DIV=8, BLANK_CYCLES=2, ACTIVE_LOW=1.
1. Hold rst=1 for 3 cycles, then release with enable=1 → during reset digit=8'hFF, select=6'h3F, frame=0. After release, the first frame shows "000000"; slot 0 active gives digit=8'hC0, select=6'h3E.
2. load value=24'h123456, dp=0, blank_lz=0 at the start of frame 0 → no change until the frame pulse. In the next frame:
   - slot 0: select=6'h3E, digit=8'h82 ('6').
   - slot 5: select=6'h1F, digit=8'hF9 ('1').
3. load value=24'h000070, dp=6'b000010, blank_lz=1 → in the next frame:
   - slots 5..2: digit=8'hFF.
   - slot 1: digit=8'h78 ('7' with dp).
   - slot 0: digit=8'hC0.
4. In any slot, select=6'h3F for the first 2 cycles, then exactly one bit low for 6 cycles. frame is high for 1 cycle every 48 cycles.
5. Drive load coincident with the frame-boundary cycle, value=24'hABCDEF → the very next frame shows slot 0 digit=8'h8E ('F'). In the same test, drop enable for 5 cycles → select=6'h3F, and on re-enable the scan restarts at slot 0.
6. Assert rst at idx=3, tick=4 → the next cycle shows digit=8'hFF, select=6'h3F; after release, slot 0 shows '0' (digit=8'hC0) because shadow was cleared.
